// File: rtl/udma_i2s_pkg.sv
// rtl/udma_i2s_pkg.sv - shared types and constants for the uDMA I2S receive path
package udma_i2s_pkg;

   localparam int I2S_DW = 32;
   localparam int WLEN_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RUN
   } rx_state_e;

   typedef logic [WLEN_W:0] rx_cnt_t;

   // MSB-first shifts in at bit 0; LSB-first places the bit at its final position.
   function automatic logic [I2S_DW-1:0] sr_insert(
      input logic [I2S_DW-1:0] sr,
      input logic              din,
      input logic [WLEN_W-1:0] idx,
      input logic              lsb_first
   );
      logic [I2S_DW-1:0] r;
      r = sr;
      if (lsb_first) begin
         r[idx] = din;
      end else begin
         r = {sr[I2S_DW-2:0], din};
      end
      return r;
   endfunction

endpackage

// File: rtl/i2s_rx_channel_if.sv
// rtl/i2s_rx_channel_if.sv - word output handshake from the I2S receive channel to the RX FIFO
interface i2s_rx_channel_if;
   import udma_i2s_pkg::*;

   logic [I2S_DW-1:0] fifo_data;
   logic              fifo_data_valid;
   logic              fifo_data_ready;
   logic              fifo_err;

   modport master (
      output fifo_data,
      output fifo_data_valid,
      output fifo_err,
      input  fifo_data_ready
   );

   modport slave (
      input  fifo_data,
      input  fifo_data_valid,
      input  fifo_err,
      output fifo_data_ready
   );

endinterface

// File: rtl/i2s_rx_channel_buf.sv
// rtl/i2s_rx_channel_buf.sv - 2-entry valid/ready output buffer with all-or-nothing frame push
module i2s_rx_buf
   import udma_i2s_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic [1:0]        push_cnt_i,
   input  logic [I2S_DW-1:0] push_data0_i,
   input  logic [I2S_DW-1:0] push_data1_i,
   output logic [I2S_DW-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              err_o
);

   logic [I2S_DW-1:0] mem0_q, mem0_d;
   logic [I2S_DW-1:0] mem1_q, mem1_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              pop;
   logic [1:0]        free;

   assign pop = (cnt_q != 2'd0) && ready_i;

   // Free space is judged after the same-cycle pop; a frame that does not fit is dropped whole.
   always_comb begin
      mem0_d = mem0_q;
      mem1_d = mem1_q;
      cnt_d  = cnt_q;
      err_d  = 1'b0;
      free   = 2'd0;
      if (pop) begin
         mem0_d = mem1_q;
         cnt_d  = cnt_q - 2'd1;
      end
      free = 2'd2 - cnt_d;
      if (push_cnt_i != 2'd0) begin
         if (free < push_cnt_i) begin
            err_d = 1'b1;
         end else if (push_cnt_i == 2'd2) begin
            mem0_d = push_data0_i;
            mem1_d = push_data1_i;
            cnt_d  = 2'd2;
         end else begin
            if (cnt_d == 2'd0) begin
               mem0_d = push_data0_i;
            end else begin
               mem1_d = push_data0_i;
            end
            cnt_d = cnt_d + 2'd1;
         end
      end
      if (flush_i) begin
         mem0_d = '0;
         mem1_d = '0;
         cnt_d  = 2'd0;
         err_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem0_q <= '0;
         mem1_q <= '0;
         cnt_q  <= 2'd0;
         err_q  <= 1'b0;
      end else begin
         mem0_q <= mem0_d;
         mem1_q <= mem1_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign data_o  = mem0_q;
   assign valid_o = (cnt_q != 2'd0);
   assign err_o   = err_q;

endmodule

// File: rtl/i2s_rx_channel.sv
// rtl/i2s_rx_channel.sv - I2S serial-to-parallel receive channel, one or two data lines, sck domain
module i2s_rx_channel
   import udma_i2s_pkg::*;
(
   input  logic              sck_i,
   input  logic              rst_i,
   input  logic              i2s_ch0_i,
   input  logic              i2s_ch1_i,
   input  logic              i2s_ws_i,
   input  logic              cfg_en_i,
   input  logic              cfg_2ch_i,
   input  logic [WLEN_W-1:0] cfg_wlen_i,
   input  logic              cfg_lsb_first_i,
   i2s_rx_channel_if.master  fifo
);

   rx_state_e         state_q, state_d;
   logic              ws_q, ws_d;
   rx_cnt_t           count_q, count_d;
   logic [I2S_DW-1:0] sr0_q, sr0_d;
   logic [I2S_DW-1:0] sr1_q, sr1_d;
   logic [1:0]        push_cnt_q, push_cnt_d;
   logic              ws_edge;
   logic              restart;
   logic              cap;
   rx_cnt_t           wlen_ext;

   assign ws_d     = i2s_ws_i;
   assign ws_edge  = i2s_ws_i ^ ws_q;
   assign wlen_ext = {1'b0, cfg_wlen_i};

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      sr0_d      = sr0_q;
      sr1_d      = sr1_q;
      push_cnt_d = 2'd0;
      restart    = 1'b0;
      cap        = 1'b0;

      case (state_q)
         ST_IDLE: if (cfg_en_i) state_d = ST_WAIT;
         ST_WAIT: begin
            if (ws_edge) begin
               restart = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (ws_edge) begin
               restart = 1'b1;
            end else if (count_q <= wlen_ext) begin
               cap = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Every word-select edge starts a fresh slot, which keeps both lines aligned to ws.
      if (restart) begin
         sr0_d   = {{(I2S_DW-1){1'b0}}, i2s_ch0_i};
         sr1_d   = cfg_2ch_i ? {{(I2S_DW-1){1'b0}}, i2s_ch1_i} : '0;
         count_d = rx_cnt_t'(1);
         if (cfg_wlen_i == '0) push_cnt_d = cfg_2ch_i ? 2'd2 : 2'd1;
      end else if (cap) begin
         sr0_d   = sr_insert(sr0_q, i2s_ch0_i, count_q[WLEN_W-1:0], cfg_lsb_first_i);
         if (cfg_2ch_i) begin
            sr1_d = sr_insert(sr1_q, i2s_ch1_i, count_q[WLEN_W-1:0], cfg_lsb_first_i);
         end
         count_d = count_q + rx_cnt_t'(1);
         if (count_q == wlen_ext) push_cnt_d = cfg_2ch_i ? 2'd2 : 2'd1;
      end

      if (!cfg_en_i) begin
         state_d    = ST_IDLE;
         count_d    = '0;
         sr0_d      = '0;
         sr1_d      = '0;
         push_cnt_d = 2'd0;
      end
   end

   always_ff @(posedge sck_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         ws_q       <= 1'b0;
         count_q    <= '0;
         sr0_q      <= '0;
         sr1_q      <= '0;
         push_cnt_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         ws_q       <= ws_d;
         count_q    <= count_d;
         sr0_q      <= sr0_d;
         sr1_q      <= sr1_d;
         push_cnt_q <= push_cnt_d;
      end
   end

   i2s_rx_buf u_buf (
      .clk_i        (sck_i),
      .rst_i        (rst_i),
      .flush_i      (~cfg_en_i),
      .push_cnt_i   (push_cnt_q),
      .push_data0_i (sr0_q),
      .push_data1_i (sr1_q),
      .data_o       (fifo.fifo_data),
      .valid_o      (fifo.fifo_data_valid),
      .ready_i      (fifo.fifo_data_ready),
      .err_o        (fifo.fifo_err)
   );

endmodule

// File: tb/tb_i2s_rx_channel.sv
// tb/tb_i2s_rx_channel.sv - directed self-checking bench for i2s_rx_channel
module tb_i2s_rx_channel;
   import udma_i2s_pkg::*;

   logic        sck = 1'b0;
   logic        rst = 1'b1;
   logic        ch0 = 1'b0;
   logic        ch1 = 1'b0;
   logic        ws  = 1'b0;
   logic        en  = 1'b0;
   logic        two_ch = 1'b0;
   logic [4:0]  wlen = 5'd0;
   logic        lsb = 1'b0;
   logic        ready = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   logic [31:0] got[$];
   int err_cycles;
   int err_rises;
   int valid_cycles;
   int first_vcyc;
   logic err_prev = 1'b0;
   int last_cyc;

   i2s_rx_channel_if fifo_if();
   assign fifo_if.fifo_data_ready = ready;

   i2s_rx_channel dut (
      .sck_i           (sck),
      .rst_i           (rst),
      .i2s_ch0_i       (ch0),
      .i2s_ch1_i       (ch1),
      .i2s_ws_i        (ws),
      .cfg_en_i        (en),
      .cfg_2ch_i       (two_ch),
      .cfg_wlen_i      (wlen),
      .cfg_lsb_first_i (lsb),
      .fifo            (fifo_if.master)
   );

   always #5 sck = ~sck;

   always @(posedge sck) cyc <= cyc + 1;

   always @(negedge sck) begin
      if (!rst) begin
         if (fifo_if.fifo_data_valid && ready) got.push_back(fifo_if.fifo_data);
         if (fifo_if.fifo_data_valid) begin
            valid_cycles++;
            if (first_vcyc < 0) first_vcyc = cyc;
         end
         if (fifo_if.fifo_err) begin
            err_cycles++;
            if (!err_prev) err_rises++;
         end
         err_prev = fifo_if.fifo_err;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
   endtask

   function automatic logic [31:0] gq(input int i);
      if (i < got.size()) return got[i];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic bitof(input logic [31:0] w, input int i);
      if (i > int'(wlen)) return 1'b1;
      if (lsb) return w[i];
      return w[int'(wlen) - i];
   endfunction

   task automatic step();
      @(posedge sck);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send_slot(input logic [31:0] w0, input logic [31:0] w1,
                            input int first, input int last);
      for (int i = first; i <= last; i++) begin
         step();
         if (i == 0) ws = ~ws;
         ch0 = bitof(w0, i);
         ch1 = bitof(w1, i);
      end
   endtask

   task automatic clr();
      got.delete();
      err_cycles   = 0;
      err_rises    = 0;
      valid_cycles = 0;
      first_vcyc   = -1;
   endtask

   task automatic reconfig(input logic c2, input logic [4:0] wl, input logic lf, input logic rdy);
      step();
      en = 1'b0;
      idle(2);
      two_ch = c2;
      wlen   = wl;
      lsb    = lf;
      ready  = rdy;
      clr();
      en = 1'b1;
      idle(2);
   endtask

   initial begin
      clr();
      idle(3);
      @(negedge sck);
      chk("rst_valid", {31'b0, fifo_if.fifo_data_valid}, 32'd0);
      chk("rst_data", fifo_if.fifo_data, 32'd0);
      chk("rst_err", {31'b0, fifo_if.fifo_err}, 32'd0);
      step();
      rst = 1'b0;

      // mono, MSB-first, 16-bit words in 16-bit slots
      reconfig(1'b0, 5'd15, 1'b0, 1'b1);
      send_slot(32'hA5C3, 32'h0, 0, 15);
      last_cyc = cyc;
      send_slot(32'h5A3C, 32'h0, 0, 15);
      idle(4);
      chk("m16_cnt", got.size(), 2);
      chk("m16_w0", gq(0), 32'h0000_A5C3);
      chk("m16_w1", gq(1), 32'h0000_5A3C);
      chk("m16_lat", first_vcyc, last_cyc + 2);
      chk("m16_vcyc", valid_cycles, 2);
      chk("m16_err", err_cycles, 0);

      // stereo, LSB-first, 8-bit words
      reconfig(1'b1, 5'd7, 1'b1, 1'b1);
      send_slot(32'h3C, 32'h81, 0, 7);
      send_slot(32'h5E, 32'h07, 0, 7);
      idle(4);
      chk("s8_cnt", got.size(), 4);
      chk("s8_w0", gq(0), 32'h3C);
      chk("s8_w1", gq(1), 32'h81);
      chk("s8_w2", gq(2), 32'h5E);
      chk("s8_w3", gq(3), 32'h07);
      chk("s8_err", err_cycles, 0);

      // 24-bit words in 32-bit slots, trailing bits are all ones
      reconfig(1'b0, 5'd23, 1'b0, 1'b1);
      send_slot(32'hFF_FFFF, 32'h0, 0, 31);
      send_slot(32'h12_3456, 32'h0, 0, 31);
      idle(4);
      chk("w24_cnt", got.size(), 2);
      chk("w24_w0", gq(0), 32'h00FF_FFFF);
      chk("w24_w1", gq(1), 32'h0012_3456);

      // overrun: buffer full for two frames, then drain
      reconfig(1'b1, 5'd7, 1'b0, 1'b0);
      send_slot(32'h11, 32'h22, 0, 7);
      send_slot(32'h33, 32'h44, 0, 7);
      send_slot(32'h55, 32'h66, 0, 7);
      idle(3);
      @(negedge sck);
      chk("ovr_hold_v", {31'b0, fifo_if.fifo_data_valid}, 32'd1);
      chk("ovr_hold_d", fifo_if.fifo_data, 32'h11);
      chk("ovr_errcyc", err_cycles, 2);
      chk("ovr_errrise", err_rises, 2);
      step();
      ready = 1'b1;
      send_slot(32'h77, 32'h88, 0, 7);
      idle(4);
      chk("ovr_cnt", got.size(), 4);
      chk("ovr_w0", gq(0), 32'h11);
      chk("ovr_w1", gq(1), 32'h22);
      chk("ovr_w2", gq(2), 32'h77);
      chk("ovr_w3", gq(3), 32'h88);

      // pop and push in the same cycle with one entry held
      reconfig(1'b0, 5'd3, 1'b0, 1'b0);
      send_slot(32'h9, 32'h0, 0, 3);
      idle(3);
      send_slot(32'h6, 32'h0, 0, 3);
      step();
      ready = 1'b1;
      idle(4);
      chk("pp_cnt", got.size(), 2);
      chk("pp_w0", gq(0), 32'h9);
      chk("pp_w1", gq(1), 32'h6);
      chk("pp_err", err_cycles, 0);

      // disable mid-word, then resync on the next ws edge
      reconfig(1'b0, 5'd15, 1'b0, 1'b0);
      send_slot(32'hBEEF, 32'h0, 0, 15);
      idle(3);
      @(negedge sck);
      chk("dis_pre_v", {31'b0, fifo_if.fifo_data_valid}, 32'd1);
      send_slot(32'h1357, 32'h0, 0, 4);
      step();
      en = 1'b0;
      @(posedge sck);
      @(negedge sck);
      chk("dis_v_low", {31'b0, fifo_if.fifo_data_valid}, 32'd0);
      step();
      clr();
      ready = 1'b1;
      en = 1'b1;
      send_slot(32'h1357, 32'h0, 5, 15);
      send_slot(32'hC0DE, 32'h0, 0, 15);
      idle(4);
      chk("dis_cnt", got.size(), 1);
      chk("dis_w0", gq(0), 32'h0000_C0DE);
      chk("dis_err", err_cycles, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
